frame_text_buffer: RTL and testbench

Character-cell frame buffer that sits directly downstream of the cycle-printing stage. It accepts single-character writes on the `frame_char`/`frame_x`/`frame_y`/`frame_we` bus and stores them in a 40x30 grid of 6-bit character codes. It also serves a pipelined scanout read port that turns VGA pixel coordinates into the character code and glyph row/column for the font stage. A hardware clear sequence blanks the grid after reset.

---
 rtl/frame_text_buffer.sv | 123 ++++++++++++
 tb/tb_frame_text_buffer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/frame_text_buffer.sv
// 40x30 character-cell frame buffer: print-bus writes, 2-cycle scanout read, no stall/backpressure.
// FRAME_CLEAR_EN adds a post-reset clear engine that blanks the grid and owns the write port while busy.
module frame_text_buffer #(
    parameter int         COLS       = 40,
    parameter int         ROWS       = 30,
    parameter logic [5:0] CLEAR_CHAR = 6'd0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] frame_char,
    input  logic [5:0] frame_x,
    input  logic [5:0] frame_y,
    input  logic       frame_we,
    input  logic [9:0] scan_x,
    input  logic [9:0] scan_y,
    output logic [5:0] scan_char,
    output logic [3:0] scan_col,
    output logic [3:0] scan_row,
    output logic       scan_valid,
    output logic       clear_busy
);

    localparam int          CELLS     = COLS * ROWS;
    localparam logic [9:0]  X_LIMIT   = 10'(COLS * 16);
    localparam logic [9:0]  Y_LIMIT   = 10'(ROWS * 16);
    localparam logic [10:0] LAST_ADDR = 11'(CELLS - 1);

    // Row stride of 40 built from shifts: y*32 + y*8 + x.
    function automatic logic [10:0] cell_addr(input logic [5:0] y, input logic [5:0] x);
        return ({5'd0, y} << 5) + ({5'd0, y} << 3) + {5'd0, x};
    endfunction

    logic [5:0]  mem [0:CELLS-1];

    logic        wr_ok;
    logic        wr_en;
    logic [10:0] wr_addr;
    logic [5:0]  wr_dat;
    logic [10:0] clr_addr;

    logic        wq_en;
    logic [10:0] wq_addr;
    logic [5:0]  wq_dat;

    logic [10:0] s1_addr;
    logic        s1_vld;
    logic [3:0]  s1_col;
    logic [3:0]  s1_row;

`ifdef FRAME_CLEAR_EN
    typedef enum logic {S_CLEAR, S_RUN} state_t;
    state_t state;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_CLEAR;
            clr_addr   <= '0;
            clear_busy <= 1'b1;
        end else begin
            case (state)
                S_CLEAR: begin
                    if (clr_addr == LAST_ADDR) begin
                        state      <= S_RUN;
                        clear_busy <= 1'b0;
                    end else begin
                        clr_addr <= clr_addr + 11'd1;
                    end
                end
                default: begin
                    state      <= S_RUN;
                    clear_busy <= 1'b0;
                end
            endcase
        end
    end
`else
    assign clear_busy = 1'b0;
    assign clr_addr   = '0;
`endif

    // Port A: the clear engine has priority; print writes only land when in range and idle.
    assign wr_ok   = frame_we && !clear_busy && (frame_x < 6'(COLS)) && (frame_y < 6'(ROWS));
    assign wr_en   = !reset && (clear_busy || wr_ok);
    assign wr_addr = clear_busy ? clr_addr : cell_addr(frame_y, frame_x);
    assign wr_dat  = clear_busy ? CLEAR_CHAR : frame_char;

    // Write is staged one cycle so a same-cycle scan of the cell still reads the old value.
    always_ff @(posedge clk) begin
        wq_en   <= wr_en;
        wq_addr <= wr_addr;
        wq_dat  <= wr_dat;
    end

    always_ff @(posedge clk) begin
        if (wq_en) begin
            mem[wq_addr] <= wq_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            s1_addr    <= '0;
            s1_vld     <= 1'b0;
            s1_col     <= '0;
            s1_row     <= '0;
            scan_char  <= '0;
            scan_col   <= '0;
            scan_row   <= '0;
            scan_valid <= 1'b0;
        end else begin
            s1_addr    <= cell_addr(scan_y[9:4], scan_x[9:4]);
            s1_vld     <= (scan_x < X_LIMIT) && (scan_y < Y_LIMIT);
            s1_col     <= scan_x[3:0];
            s1_row     <= scan_y[3:0];
            // Off-screen addresses may exceed the grid; their data is masked here.
            scan_char  <= s1_vld ? mem[s1_addr] : 6'd0;
            scan_col   <= s1_col;
            scan_row   <= s1_row;
            scan_valid <= s1_vld;
        end
    end

endmodule

// File: tb/tb_frame_text_buffer.sv
// Directed bench for frame_text_buffer with a scoreboard queue of expected scanout results.
module tb_frame_text_buffer;

    logic       clk;
    logic       reset;
    logic [5:0] frame_char;
    logic [5:0] frame_x;
    logic [5:0] frame_y;
    logic       frame_we;
    logic [9:0] scan_x;
    logic [9:0] scan_y;
    logic [5:0] scan_char;
    logic [3:0] scan_col;
    logic [3:0] scan_row;
    logic       scan_valid;
    logic       clear_busy;

    frame_text_buffer dut (
        .clk        (clk),
        .reset      (reset),
        .frame_char (frame_char),
        .frame_x    (frame_x),
        .frame_y    (frame_y),
        .frame_we   (frame_we),
        .scan_x     (scan_x),
        .scan_y     (scan_y),
        .scan_char  (scan_char),
        .scan_col   (scan_col),
        .scan_row   (scan_row),
        .scan_valid (scan_valid),
        .clear_busy (clear_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

`ifdef FRAME_CLEAR_EN
    localparam bit EXP_BUSY = 1'b1;
`else
    localparam bit EXP_BUSY = 1'b0;
`endif

    typedef struct {
        bit         chk;
        bit         ch_known;
        logic [5:0] ch;
        logic [3:0] col;
        logic [3:0] row;
        logic       vld;
        string      tag;
    } exp_t;

    exp_t       q[$];
    logic [5:0] model [0:1199];
    bit         known [0:1199];
    int         busy_left = 0;
    int         n_assert  = 0;
    int         n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, record the expected scanout, apply the write to the model,
    // then compare the output whose coordinates were driven one cycle earlier.
    task automatic cyc(input bit we, input logic [5:0] ch, input logic [5:0] x, input logic [5:0] y,
                       input logic [9:0] sx, input logic [9:0] sy, input bit chk, input string tag);
        exp_t e;
        int   a;
        frame_we   = we;
        frame_char = ch;
        frame_x    = x;
        frame_y    = y;
        scan_x     = sx;
        scan_y     = sy;
        e.chk      = chk;
        e.tag      = tag;
        e.vld      = (sx < 10'd640) && (sy < 10'd480);
        e.col      = sx[3:0];
        e.row      = sy[3:0];
        e.ch       = 6'd0;
        e.ch_known = 1'b1;
        if (e.vld) begin
            a          = (int'(sy) / 16) * 40 + int'(sx) / 16;
            e.ch       = model[a];
            e.ch_known = known[a];
        end
        q.push_back(e);
        if (we && x < 6'd40 && y < 6'd30 && busy_left == 0) begin
            model[int'(y) * 40 + int'(x)] = ch;
            known[int'(y) * 40 + int'(x)] = 1'b1;
        end
        @(posedge clk);
        #1;
        if (busy_left > 0) busy_left--;
        if (q.size() == 2) begin
            e = q.pop_front();
            if (e.chk) begin
                check({e.tag, "_valid"}, 32'(scan_valid), 32'(e.vld));
                check({e.tag, "_col"}, 32'(scan_col), 32'(e.col));
                check({e.tag, "_row"}, 32'(scan_row), 32'(e.row));
                if (e.ch_known) check({e.tag, "_char"}, 32'(scan_char), 32'(e.ch));
            end
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b0, 6'd0, 6'd0, 6'd0, 10'd700, 10'd500, 1'b0, "idle");
    endtask

    task automatic scan(input logic [9:0] sx, input logic [9:0] sy, input string tag);
        cyc(1'b0, 6'd0, 6'd0, 6'd0, sx, sy, 1'b1, tag);
    endtask

    task automatic write(input logic [5:0] ch, input logic [5:0] x, input logic [5:0] y);
        cyc(1'b1, ch, x, y, 10'd700, 10'd500, 1'b0, "wr");
    endtask

    task automatic do_reset();
        exp_t f;
        reset    = 1'b1;
        frame_we = 1'b0;
        scan_x   = 10'd100;
        scan_y   = 10'd100;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_char", 32'(scan_char), 32'd0);
        check("rst_col", 32'(scan_col), 32'd0);
        check("rst_row", 32'(scan_row), 32'd0);
        check("rst_valid", 32'(scan_valid), 32'd0);
        check("rst_busy", 32'(clear_busy), 32'(EXP_BUSY));
        q.delete();
        f.chk = 1'b1; f.ch_known = 1'b1; f.ch = '0; f.col = '0; f.row = '0; f.vld = 1'b0; f.tag = "flush";
        q.push_back(f);
`ifdef FRAME_CLEAR_EN
        busy_left = 1200;
        for (int i = 0; i < 1200; i++) begin
            model[i] = 6'd0;
            known[i] = 1'b1;
        end
`endif
    endtask

`ifdef FRAME_CLEAR_EN
    // Counts cycles with clear_busy high after a reset; optionally tries a write at loop index we_at.
    task automatic count_busy(input int we_at, input string tag);
        int n = 1;
        for (int i = 0; i < 3000; i++) begin
            if (i == we_at) write(6'd9, 6'd0, 6'd0);
            else idle(1);
            if (!clear_busy) break;
            n++;
        end
        check(tag, 32'(n), 32'd1200);
    endtask
`endif

    initial begin
        int cx[8];
        int cy[8];
        reset = 1'b1; frame_we = 1'b0; frame_char = '0; frame_x = '0; frame_y = '0;
        scan_x = '0; scan_y = '0;
        for (int i = 0; i < 1200; i++) begin
            model[i] = 6'd0;
            known[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        do_reset();

`ifdef FRAME_CLEAR_EN
        count_busy(-1, "clear_len_poweron");
        write(6'd17, 6'd3, 6'd2);
        scan(10'd48, 10'd32, "preload");
        idle(2);
        do_reset();
        count_busy(4, "clear_len_with_write");
        scan(10'd48, 10'd32, "cleared_cell");
        scan(10'd0, 10'd0, "drop_during_clear");
        idle(2);
        do_reset();
        idle(600);
        do_reset();
        count_busy(-1, "clear_restart");
        check("busy_low_after", 32'(clear_busy), 32'd0);
`endif

        // Write then read the bottom-right corner.
        write(6'd37, 6'd39, 6'd29);
        scan(10'd639, 10'd479, "corner");
        idle(2);

        // Out-of-range column must not wrap into row 1.
        write(6'd0, 6'd0, 6'd1);
        write(6'd0, 6'd39, 6'd0);
        write(6'd5, 6'd40, 6'd0);
        write(6'd6, 6'd0, 6'd30);
        scan(10'd0, 10'd16, "oor_wr_row1");
        scan(10'd624, 10'd0, "oor_wr_col39");
        idle(2);

        // Off-screen scans, then back-to-back valid.
        scan(10'd650, 10'd100, "oor_scan_x");
        scan(10'd639, 10'd479, "after_oor");
        scan(10'd100, 10'd480, "oor_scan_y");
        idle(2);

        // Same-cycle write and scan of one cell.
        write(6'd0, 6'd1, 6'd1);
        idle(1);
        cyc(1'b1, 6'd12, 6'd1, 6'd1, 10'd16, 10'd16, 1'b1, "collide_old");
        scan(10'd16, 10'd16, "collide_new");
        idle(2);

        for (int k = 0; k < 8; k++) begin
            cx[k] = $urandom_range(0, 39);
            cy[k] = $urandom_range(0, 29);
            write(6'($urandom_range(1, 63)), 6'(cx[k]), 6'(cy[k]));
        end
        for (int k = 0; k < 8; k++) begin
            scan(10'(cx[k] * 16 + $urandom_range(0, 15)), 10'(cy[k] * 16 + $urandom_range(0, 15)), "rand");
        end
        idle(2);

`ifndef FRAME_CLEAR_EN
        write(6'd21, 6'd5, 6'd5);
        idle(2);
        do_reset();
        scan(10'd80, 10'd80, "survive_reset");
        idle(2);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
